// File: rtl/ysyx_22050612_dmem_responder.sv
// Data-memory responder: one request at a time over valid/ready, fixed-latency service
// from an internal 64-bit word array. Optional range checking via DMEM_RANGE_CHECK_EN.
module ysyx_22050612_dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [63:0]           r_mem [DEPTH];
    logic [CNT_W-1:0]      r_cnt;
    logic [63:0]           r_addr;
    logic [63:0]           r_wdata;
    logic [7:0]            r_wmask;
    logic                  r_wen;
    logic [63:0]           r_rsp_rdata;
    logic                  r_rsp_err;

    logic [63:0]           w_off;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_err;
    logic                  w_commit;
    logic                  w_mem_we;
    logic                  w_req_ready;
    logic                  w_rsp_valid;
    logic                  w_unused_ok;

    function automatic logic [63:0] f_merge(input logic [63:0] old_word,
                                            input logic [63:0] new_word,
                                            input logic [7:0]  mask);
        logic [63:0] res;
        res = old_word;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign w_off    = r_addr - BASE_ADDR;
    assign w_idx    = w_off[DEPTH_LOG2+2:3];
    assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);
    // Out-of-range writes must never touch the array, hence the w_err gate.
    assign w_mem_we = w_commit && r_wen && !w_err;

`ifdef DMEM_RANGE_CHECK_EN
    assign w_err       = (w_off[63:DEPTH_LOG2+3] != '0);
    assign w_unused_ok = &{1'b0, w_off[2:0]};
`else
    assign w_err       = 1'b0;
    assign w_unused_ok = &{1'b0, w_off[2:0], w_off[63:DEPTH_LOG2+3]};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = S_WAIT; else w_state_nxt = S_IDLE;
            S_WAIT:  if (r_cnt == '0) w_state_nxt = S_RESP; else w_state_nxt = S_WAIT;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE; else w_state_nxt = S_RESP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_req_ready = 1'b1;
            S_WAIT:  w_req_ready = 1'b0;
            S_RESP:  w_rsp_valid = 1'b1;
            default: w_req_ready = 1'b0;
        endcase
    end

    // Request latch, latency counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_addr      <= 64'd0;
            r_wdata     <= 64'd0;
            r_wmask     <= 8'd0;
            r_wen       <= 1'b0;
            r_rsp_rdata <= 64'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_wmask <= req_wmask;
                        r_wen   <= req_wen;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_rdata <= (r_wen || w_err) ? 64'd0 : r_mem[w_idx];
                        r_rsp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= f_merge(r_mem[w_idx], r_wdata, r_wmask);
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = w_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ysyx_22050612_dmem_responder.sv
// Self-checking bench for ysyx_22050612_dmem_responder: vector table plus
// hand-written reset sequences, with a scoreboard queue of expected responses.
module tb_ysyx_22050612_dmem_responder;

    localparam int LAT = 2;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    ysyx_22050612_dmem_responder #(
        .DEPTH_LOG2(12),
        .LATENCY   (LAT),
        .BASE_ADDR (64'h8000_0000)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_wen  (req_wen),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          hold;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    function automatic void add(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [7:0] wmask, input int hold,
                                input logic [63:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
        v.hold = hold; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    task automatic drive_idle();
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0;
        req_wdata = 64'd0; req_wmask = 8'd0;
    endtask

    task automatic run(input vec_t v, input int id);
        int          n;
        exp_t        e;
        logic [63:0] held;
        req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr;
        req_wdata = v.wdata; req_wmask = v.wmask;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk($sformatf("v%0d ready before accept", id), 64'(req_ready), 64'd1);
        if (!req_ready) begin
            drive_idle();
            return;
        end
        @(posedge clk);
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        #1;
        drive_idle();
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk($sformatf("v%0d latency", id), 64'(n), 64'(LAT));
        held = rsp_rdata;
        for (int k = 0; k < v.hold; k++) begin
            // Spurious write while stalled: must be ignored.
            req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0008;
            req_wdata = 64'd0; req_wmask = 8'hFF;
            @(posedge clk); #1;
            chk($sformatf("v%0d hold%0d rsp_valid", id, k), 64'(rsp_valid), 64'd1);
            chk($sformatf("v%0d hold%0d rdata stable", id, k), rsp_rdata, held);
            chk($sformatf("v%0d hold%0d req_ready", id, k), 64'(req_ready), 64'd0);
        end
        e = sb.pop_front();
        chk($sformatf("v%0d rdata", id), rsp_rdata, e.rdata);
        chk($sformatf("v%0d err", id), 64'(rsp_err), 64'(e.err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_idle();
        chk($sformatf("v%0d rsp_valid after handshake", id), 64'(rsp_valid), 64'd0);
        chk($sformatf("v%0d req_ready after handshake", id), 64'(req_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rd;
        int   n;
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset rsp_err", 64'(rsp_err), 64'd0);
        chk("reset rsp_rdata", rsp_rdata, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        add(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0, 64'd0, 1'b0);
        add(1'b0, 64'h8000_000C, 64'd0, 8'h00, 0, 64'h1122_3344_5566_7788, 1'b0);
        add(1'b1, 64'h8000_0008, 64'hAABB_CCDD_0000_0000, 8'hF0, 0, 64'd0, 1'b0);
        add(1'b0, 64'h8000_0008, 64'd0, 8'h00, 5, 64'hAABB_CCDD_5566_7788, 1'b0);
        add(1'b0, 64'h8000_000F, 64'd0, 8'h00, 0, 64'hAABB_CCDD_5566_7788, 1'b0);
        add(1'b1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 64'd0, 1'b0);
        add(1'b1, 64'h8000_0018, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, 64'd0, 1'b0);
        add(1'b1, 64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 64'd0, 1'b0);
        add(1'b1, 64'h8000_0018, 64'h11FF_FFFF_FFFF_FF22, 8'h81, 0, 64'd0, 1'b0);
        add(1'b0, 64'h8000_0018, 64'd0, 8'hFF, 0, 64'h11AD_BEEF_CAFE_F022, 1'b0);
        add(1'b1, 64'h8000_7FF8, 64'h0000_0000_0000_0077, 8'hFF, 0, 64'd0, 1'b0);
        add(1'b0, 64'h8000_7FF8, 64'd0, 8'hFF, 0, 64'h0000_0000_0000_0077, 1'b0);
        add(1'b1, 64'h7FFF_FFF8, 64'h0000_0000_0000_005A, 8'hFF, 0, 64'd0, RC);
        add(1'b0, 64'h8000_7FF8, 64'd0, 8'h00, 0, RC ? 64'h77 : 64'h5A, 1'b0);
        add(1'b0, 64'h8000_8008, 64'd0, 8'h00, 0, RC ? 64'd0 : 64'hAABB_CCDD_5566_7788, RC);

        for (int i = 0; i < vecs.size(); i++) begin
            run(vecs[i], i);
        end

        // Reset one cycle into WAIT: the pending write must be abandoned.
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0010;
        req_wdata = 64'h5555_5555_5555_5555; req_wmask = 8'hFF;
        chk("midwait ready before accept", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midwait rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midwait rst req_ready", 64'(req_ready), 64'd1);
        chk("midwait rst rsp_rdata", rsp_rdata, 64'd0);
        chk("midwait rst rsp_err", 64'(rsp_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("midwait no rsp %0d", k), 64'(rsp_valid), 64'd0);
        end
        rd.wen = 1'b0; rd.addr = 64'h8000_0010; rd.wdata = 64'd0; rd.wmask = 8'h00;
        rd.hold = 0; rd.exp_rdata = 64'h0123_4567_89AB_CDEF; rd.exp_err = 1'b0;
        run(rd, 100);

        // Reset while in RESP drops rsp_valid without a clock edge.
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0008; req_wmask = 8'h00;
        @(posedge clk); #1;
        drive_idle();
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("resp-state rsp_valid before reset", 64'(rsp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("resp-state rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("resp-state rst req_ready", 64'(req_ready), 64'd1);
        chk("resp-state rst rsp_rdata", rsp_rdata, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
